// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/arb_priority_sel.sv
// Grant decision for the memory port: D-side wins unless the I-side is starved;
// a flush blocks a new I-grant for that cycle.
module arb_priority_sel (
  input  logic d_req_i,
  input  logic i_req_i,
  input  logic flush_i,
  input  logic starved_i,
  output logic grant_d_o,
  output logic grant_i_o
);

  always_comb begin
    grant_d_o = d_req_i && !(i_req_i && starved_i);
    grant_i_o = !grant_d_o && i_req_i && !flush_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access.
// Optional bus-timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  output logic                i_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                arb_err
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                drop_i_q, drop_i_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic                grant_d, grant_i, timeout, complete;
  owner_t              owner;

  arb_priority_sel u_sel (
    .d_req_i   (d_req),
    .i_req_i   (i_req),
    .flush_i   (flush),
    .starved_i (starve_q == STARVE_LIM),
    .grant_d_o (grant_d),
    .grant_i_o (grant_i)
  );

  assign owner    = (state_q == BUSY_I) ? OWN_I : OWN_D;
  assign complete = mem_ready || timeout;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    drop_i_d    = drop_i_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        drop_i_d = 1'b0;
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          if (!i_req)                    starve_d = '0;
          else if (starve_q != STARVE_LIM) starve_d = starve_q + STARVE_W'(1);
        end else if (grant_i) begin
          state_d     = BUSY_I;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          starve_d    = '0;
        end else if (!i_req) begin
          starve_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (owner == OWN_I && flush) drop_i_d = 1'b1;
        if (complete) begin
          // A flush landing on the completion edge suppresses the fetch just like a stored drop.
          state_d  = IDLE;
          drop_i_d = 1'b0;
          if (owner == OWN_I) begin
            if (!(drop_i_q || flush)) begin
              i_valid_d = 1'b1;
              i_rdata_d = mem_ready ? mem_rdata : '0;
            end
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q || !mem_ready) d_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      drop_i_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      drop_i_q    <= drop_i_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] busy_cnt_q, busy_cnt_d;
  logic            arb_err_q;

  assign timeout = (state_q != IDLE) && !mem_ready &&
                   (busy_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (state_q == IDLE) begin
      if (grant_d || grant_i) busy_cnt_d = '0;
    end else begin
      busy_cnt_d = busy_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      arb_err_q  <= timeout;
    end
  end

  assign arb_err = arb_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout            = 1'b0;
  assign arb_err            = 1'b0;
`endif

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_rdata   = i_rdata_q;
  assign i_valid   = i_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign i_stall   = i_req && !i_valid_q;
  assign d_stall   = d_req && !d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the timeout case follows MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, flush, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_valid, i_stall, d_valid, d_stall, mem_req, mem_we, arb_err;
  logic [3:0]  mem_be;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .STARVE_MAX     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_valid   (i_valid),
    .i_stall   (i_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .d_stall   (d_stall),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .arb_err   (arb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [31:0] gseq [6];
    logic [31:0] ma;
    logic        prev_req;
    int          ngr, nd, dbefore;

    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; flush = 1'b0;
    mem_ready = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; d_be = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_i_valid", i_valid, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_arb_err", arb_err, 0);
    rst = 1'b0;

    // Single load at 0x100, memory answers two cycles after mem_req
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
    #1 check("ld_stall0", d_stall, 1);
    @(negedge clk);
    check("ld_mem_req", mem_req, 1);
    check("ld_mem_addr", mem_addr, 32'h100);
    check("ld_mem_we", mem_we, 0);
    check("ld_stall1", d_stall, 1);
    @(negedge clk);
    check("ld_mem_req2", mem_req, 1);
    check("ld_valid_early", d_valid, 0);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    check("ld_valid", d_valid, 1);
    check("ld_rdata", d_rdata, 32'hDEADBEEF);
    check("ld_stall_clr", d_stall, 0);
    check("ld_idle", mem_req, 0);
    d_req = 1'b0;
    @(negedge clk);
    check("ld_valid_pulse", d_valid, 0);

    // Contention: both sides held, memory answers one cycle after each grant
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h300;
    for (int k = 0; k < 6; k++) gseq[k] = '0;
    ngr = 0; nd = 0; dbefore = -1; prev_req = 1'b0;
    for (int c = 0; c < 40 && ngr < 6; c++) begin
      @(negedge clk);
      if (d_valid) nd++;
      if (i_valid && dbefore < 0) begin
        dbefore = nd;
        check("ct_i_rdata", i_rdata, 32'hC0DE0040);
      end
      if (mem_req && !prev_req) begin
        gseq[ngr] = mem_addr;
        ngr++;
      end
      prev_req  = mem_req;
      mem_ready = mem_req;
      ma        = mem_addr;
      mem_rdata = {16'hC0DE, ma[15:0]};
    end
    check("ct_grant0", gseq[0], 32'h300);
    check("ct_grant1", gseq[1], 32'h300);
    check("ct_grant2", gseq[2], 32'h300);
    check("ct_grant3", gseq[3], 32'h300);
    check("ct_grant4", gseq[4], 32'h40);
    check("ct_grant5", gseq[5], 32'h300);
    check("ct_dvalid_before_i", 32'(dbefore), 32'd4);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    check("ct_last_rdata", d_rdata, 32'hC0DE0300);
    @(negedge clk);
    check("ct_idle", mem_req, 0);

    // Flush while a fetch is outstanding: response dropped, refetch at 0x200
    i_req = 1'b1; i_addr = 32'h80;
    @(negedge clk);
    check("fl_mem_addr", mem_addr, 32'h80);
    check("fl_i_stall", i_stall, 1);
    flush = 1'b1; i_addr = 32'h200;
    @(negedge clk);
    flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h00000013;
    @(negedge clk);
    mem_ready = 1'b0;
    check("fl_no_valid", i_valid, 0);
    check("fl_idle", mem_req, 0);
    @(negedge clk);
    check("fl_regrant", mem_req, 1);
    check("fl_new_addr", mem_addr, 32'h200);
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    @(negedge clk);
    mem_ready = 1'b0;
    check("fl_valid", i_valid, 1);
    check("fl_rdata", i_rdata, 32'h00500093);
    i_req = 1'b0;
    @(negedge clk);
    check("fl_valid_pulse", i_valid, 0);

    // Flush on the mem_ready edge of a fetch; pending store wins the next idle cycle
    i_req = 1'b1; i_addr = 32'h240;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h11111111; flush = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hCAFEF00D; d_be = 4'b0011;
    @(negedge clk);
    check("fc_no_valid", i_valid, 0);
    check("fc_idle", mem_req, 0);
    flush = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("fc_d_grant", mem_addr, 32'h400);
    check("fc_we", mem_we, 1);
    check("fc_wdata", mem_wdata, 32'hCAFEF00D);
    check("fc_be", mem_be, 32'h3);
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("st_valid", d_valid, 1);
    check("st_rdata_hold", d_rdata, 32'hC0DE0300);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("fc_i_regrant", mem_addr, 32'h240);
    mem_ready = 1'b1; mem_rdata = 32'h00000077;
    @(negedge clk);
    check("fc_i_valid", i_valid, 1);
    check("fc_i_rdata", i_rdata, 32'h00000077);
    i_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: abort after 8 busy cycles
    d_req = 1'b1; d_addr = 32'h600;
    repeat (8) @(negedge clk);
    check("to_still_busy", mem_req, 1);
    check("to_err_early", arb_err, 0);
    @(negedge clk);
    check("to_err", arb_err, 1);
    check("to_d_valid", d_valid, 1);
    check("to_d_rdata", d_rdata, 0);
    check("to_idle", mem_req, 0);
    d_req = 1'b0;
    @(negedge clk);
    check("to_err_pulse", arb_err, 0);
`else
    // Without the timeout the arbiter waits indefinitely
    d_req = 1'b1; d_addr = 32'h600;
    repeat (12) @(negedge clk);
    check("nt_still_busy", mem_req, 1);
    check("nt_no_err", arb_err, 0);
    check("nt_no_valid", d_valid, 0);
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ready = 1'b0;
    check("nt_d_valid", d_valid, 1);
    check("nt_d_rdata", d_rdata, 32'h12345678);
    d_req = 1'b0;
    @(negedge clk);
`endif

    // Reset in BUSY_D, then a late mem_ready
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    @(negedge clk);
    check("rb_busy", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rb_mem_req", mem_req, 0);
    check("rb_mem_addr", mem_addr, 0);
    check("rb_i_rdata", i_rdata, 0);
    check("rb_d_rdata", d_rdata, 0);
    check("rb_d_valid", d_valid, 0);
    rst = 1'b0; d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("rb_late_ready", d_valid, 0);
    check("rb_still_idle", mem_req, 0);
    mem_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
